// File: rtl/pov_loader_if.sv
// pov_loader_if: bundles the SPI host link, the frame tick and the staged
// point-of-view vector set that pov_loader presents to the raybox core.
// master = host/consumer side, slave = pov_loader.
interface pov_loader_if #(
  parameter int unsigned W = 24
);
  logic         tick;
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_csb;
  logic [W-1:0] new_playerX;
  logic [W-1:0] new_playerY;
  logic [W-1:0] new_facingX;
  logic [W-1:0] new_facingY;
  logic [W-1:0] new_vplaneX;
  logic [W-1:0] new_vplaneY;
  logic         write_new_position;
  logic         frame_err;

  modport master (
    output tick, spi_sclk, spi_mosi, spi_csb,
    input  new_playerX, new_playerY, new_facingX, new_facingY,
           new_vplaneX, new_vplaneY, write_new_position, frame_err
  );

  modport slave (
    input  tick, spi_sclk, spi_mosi, spi_csb,
    output new_playerX, new_playerY, new_facingX, new_facingY,
           new_vplaneX, new_vplaneY, write_new_position, frame_err
  );
endinterface

// File: rtl/pov_loader.sv
// pov_loader: SPI mode-0 slave that receives a 6-vector point-of-view set,
// synchronizes it into clk, validates frame length (and optionally a
// trailing XOR checksum byte) and presents the set atomically with a
// write_new_position flag held until a frame tick consumes it.
// Optional feature macro: POV_LOADER_CHECKSUM_EN (adds checksum byte).
module pov_loader #(
  parameter int unsigned W    = 24,
  parameter int unsigned NVEC = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  pov_loader_if.slave bus
);

`ifdef POV_LOADER_CHECKSUM_EN
  localparam int unsigned CK = 8;
`else
  localparam int unsigned CK = 0;
`endif
  localparam int unsigned LD = NVEC * W;
  localparam int unsigned L  = LD + CK;
  localparam logic [7:0]  L_CNT = 8'(L);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [2:0]   r_sclk_s;
  logic [1:0]   r_mosi_s;
  logic [2:0]   r_csb_s;
  state_t       r_state;
  state_t       w_next;
  logic         w_start;
  logic         w_shift;
  logic         w_done;
  logic         w_good;
  logic         w_ck_ok;
  logic [L-1:0] r_shift;
  logic [7:0]   r_cnt;
  logic         r_accept;
  logic         r_frame_err;
  logic [W-1:0] r_vec [NVEC];
  logic         r_wpos;

  wire w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  wire w_csb_fall  = ~r_csb_s[1] & r_csb_s[2];
  wire w_csb_rise  = r_csb_s[1] & ~r_csb_s[2];
  wire w_mosi      = r_mosi_s[1];

  // Two-flop synchronizers plus an edge-detect stage on sclk and csb
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sclk_s <= 3'b000;
      r_mosi_s <= 2'b00;
      r_csb_s  <= 3'b111;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], bus.spi_sclk};
      r_mosi_s <= {r_mosi_s[0], bus.spi_mosi};
      r_csb_s  <= {r_csb_s[1:0], bus.spi_csb};
    end
  end

  // Receive FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Receive FSM next state and datapath controls
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_csb_fall) begin
          w_next  = S_SHIFT;
          w_start = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_csb_rise) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef POV_LOADER_CHECKSUM_EN
  logic [7:0] w_xor;

  // XOR of all data bytes compared with the trailing checksum byte
  always_comb begin
    w_xor = '0;
    for (int unsigned i = 0; i < LD / 8; i++) begin
      w_xor = w_xor ^ r_shift[CK + 8*i +: 8];
    end
    w_ck_ok = (w_xor == r_shift[7:0]);
  end
`else
  assign w_ck_ok = 1'b1;
`endif

  assign w_good = (r_cnt == L_CNT) && w_ck_ok;

  // Shift register, saturating bit counter and frame verdict pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_accept    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_accept    <= w_done & w_good;
      r_frame_err <= w_done & ~w_good;
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_shift <= {r_shift[L-2:0], w_mosi};
        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Staged vector set and valid flag; an accept outranks a consuming tick
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NVEC; k++) r_vec[k] <= '0;
      r_wpos <= 1'b0;
    end else if (r_accept) begin
      for (int unsigned k = 0; k < NVEC; k++) r_vec[k] <= r_shift[L-1-k*W -: W];
      r_wpos <= 1'b1;
    end else if (bus.tick && r_wpos) begin
      r_wpos <= 1'b0;
    end
  end

  assign bus.new_playerX        = r_vec[0];
  assign bus.new_playerY        = r_vec[1];
  assign bus.new_facingX        = r_vec[2];
  assign bus.new_facingY        = r_vec[3];
  assign bus.new_vplaneX        = r_vec[4];
  assign bus.new_vplaneY        = r_vec[5];
  assign bus.write_new_position = r_wpos;
  assign bus.frame_err          = r_frame_err;

endmodule

// File: tb/tb_pov_loader.sv
// tb_pov_loader: table-driven frame tests plus hand sequences for
// accept/tick coincidence, back-to-back frames and reset mid-frame.
// Build with POV_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_pov_loader;
  localparam int unsigned W    = 24;
  localparam int unsigned NVEC = 6;
`ifdef POV_LOADER_CHECKSUM_EN
  localparam int L_TB = 152;
`else
  localparam int L_TB = 144;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pov_loader_if #(.W(W)) bus();

  pov_loader #(.W(W), .NVEC(NVEC)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        name;
    logic [143:0] data;
    int           nbits;
    logic [7:0]   mask;
    logic [143:0] exp_set;
    logic         exp_acc;
    logic         exp_err;
  } vec_t;

  vec_t tbl [7];

  localparam logic [143:0] SET_A  = {24'h001800, 24'h00D800, 24'h000000,
                                     24'hFFF000, 24'h000800, 24'h000000};
  localparam logic [143:0] SET_A2 = {24'h002800, 24'h00D800, 24'h000000,
                                     24'hFFF000, 24'h000800, 24'h000000};
  localparam logic [143:0] SET_B  = {24'h123456, 24'h789ABC, 24'hDEF012,
                                     24'h345678, 24'h9ABCDE, 24'hF01234};
  localparam logic [143:0] SET_C  = {24'hA5A5A5, 24'h5A5A5A, 24'h0F0F0F,
                                     24'hF0F0F0, 24'h000001, 24'h800000};

  function automatic logic [143:0] cur_set();
    return {bus.new_playerX, bus.new_playerY, bus.new_facingX,
            bus.new_facingY, bus.new_vplaneX, bus.new_vplaneY};
  endfunction

  // Bit image of a frame, MSB first from bit 199; mask corrupts the
  // checksum byte, or forms the surplus byte of an over-long frame.
  function automatic logic [199:0] make_buf(input logic [143:0] d, input logic [7:0] mask);
    logic [199:0] b;
    logic [7:0]   ck;
    b  = '0;
    ck = '0;
    for (int k = 0; k < 18; k++) ck = ck ^ d[143-8*k -: 8];
`ifdef POV_LOADER_CHECKSUM_EN
    b[199 -: 152] = {d, ck ^ mask};
`else
    b[199 -: 144] = d;
    b[55 -: 8]    = mask;
`endif
    return b;
  endfunction

  task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drops csb and clocks out n bits at clk/4; leaves csb low at a negedge
  task automatic send_bits(input logic [199:0] b, input int n);
    @(negedge clk);
    bus.spi_csb = 1'b0;
    clk_n(8);
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = b[199-i];
      clk_n(2);
      bus.spi_sclk = 1'b1;
      clk_n(2);
      bus.spi_sclk = 1'b0;
    end
    clk_n(2);
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic run_window(output int errs, output int rise);
    errs = 0;
    rise = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.frame_err) errs++;
      if (bus.write_new_position && rise == 0) rise = c;
    end
  endtask

  initial begin
    int errs;
    int rise;

    tbl[0] = '{"good_A", SET_A, L_TB,     8'h00, SET_A, 1'b1, 1'b0};
    tbl[1] = '{"short",  SET_B, L_TB - 1, 8'h00, SET_A, 1'b0, 1'b1};
    tbl[2] = '{"long",   SET_B, L_TB + 8, 8'h3C, SET_A, 1'b0, 1'b1};
    tbl[3] = '{"empty",  SET_B, 0,        8'h00, SET_A, 1'b0, 1'b1};
    tbl[4] = '{"plus1",  SET_B, L_TB + 1, 8'h00, SET_A, 1'b0, 1'b1};
`ifdef POV_LOADER_CHECKSUM_EN
    tbl[5] = '{"bad_ck", SET_B, L_TB,     8'h5A, SET_A, 1'b0, 1'b1};
`else
    tbl[5] = '{"short8", SET_B, L_TB - 8, 8'h00, SET_A, 1'b0, 1'b1};
`endif
    tbl[6] = '{"good_B", SET_B, L_TB,     8'h00, SET_B, 1'b1, 1'b0};

    reset_n      = 1'b0;
    bus.tick     = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_csb  = 1'b1;
    clk_n(3);
    check("reset/set",  cur_set(), '0);
    check("reset/wpos", 144'(bus.write_new_position), 144'(0));
    check("reset/err",  144'(bus.frame_err), 144'(0));
    reset_n = 1'b1;
    clk_n(4);

    for (int i = 0; i < 7; i++) begin
      send_bits(make_buf(tbl[i].data, tbl[i].mask), tbl[i].nbits);
      bus.spi_csb = 1'b1;
      run_window(errs, rise);
      check($sformatf("%s/err_pulses", tbl[i].name), 144'(errs), 144'(tbl[i].exp_err));
      check($sformatf("%s/latency", tbl[i].name), 144'(rise), tbl[i].exp_acc ? 144'(4) : 144'(0));
      check($sformatf("%s/set", tbl[i].name), cur_set(), tbl[i].exp_set);
      check($sformatf("%s/wpos", tbl[i].name), 144'(bus.write_new_position), 144'(tbl[i].exp_acc));
      do_tick();
      check($sformatf("%s/wpos_after_tick", tbl[i].name), 144'(bus.write_new_position), 144'(0));
      check($sformatf("%s/set_held", tbl[i].name), cur_set(), tbl[i].exp_set);
      clk_n(4);
    end

    // Accept load coincides with a tick
    send_bits(make_buf(SET_C, 8'h00), L_TB);
    bus.spi_csb = 1'b1;
    clk_n(3);
    check("coinc/set_before", cur_set(), SET_B);
    check("coinc/wpos_before", 144'(bus.write_new_position), 144'(0));
    do_tick();
    check("coinc/set", cur_set(), SET_C);
    check("coinc/wpos", 144'(bus.write_new_position), 144'(1));
    clk_n(3);
    do_tick();
    check("coinc/wpos_next_tick", 144'(bus.write_new_position), 144'(0));
    check("coinc/set_held", cur_set(), SET_C);
    clk_n(4);

    // Two frames with no tick between: last one wins
    send_bits(make_buf(SET_A, 8'h00), L_TB);
    bus.spi_csb = 1'b1;
    clk_n(10);
    check("b2b/first_set", cur_set(), SET_A);
    send_bits(make_buf(SET_A2, 8'h00), L_TB);
    bus.spi_csb = 1'b1;
    clk_n(10);
    check("b2b/set", cur_set(), SET_A2);
    check("b2b/wpos", 144'(bus.write_new_position), 144'(1));
    do_tick();
    check("b2b/wpos_after_tick", 144'(bus.write_new_position), 144'(0));
    check("b2b/set_held", cur_set(), SET_A2);
    clk_n(4);

    // Reset in the middle of a frame
    send_bits(make_buf(SET_B, 8'h00), 40);
    reset_n     = 1'b0;
    bus.spi_csb = 1'b1;
    clk_n(3);
    reset_n = 1'b1;
    run_window(errs, rise);
    check("midreset/err_pulses", 144'(errs), 144'(0));
    check("midreset/wpos_rise", 144'(rise), 144'(0));
    check("midreset/set", cur_set(), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pov_loader.md
Name: pov_loader

Overview:
- Upstream of the raybox top level; sole driver of its `write_new_position` and `new_playerX..new_vplaneY` inputs.
- Receives a complete point-of-view vector set (6 × Q`Qm`.`Qn`) from an external host over a 3-wire SPI-mode-0 slave link.
- Brings each set into the `clk` domain, checks it, and presents it atomically.
- Holds `write_new_position` until a frame `tick` has consumed the set.

Parameters:
- W, 24, width of one fixed-point value (must equal `Qmn`).
- NVEC, 6, vectors per set; order playerX, playerY, facingX, facingY, vplaneX, vplaneY.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle frame-start strobe (h==0 && v==0).
- spi_sclk  in  1  SPI clock, asynchronous to clk, ≤ clk/4.
- spi_mosi  in  1  SPI data, MSB first.
- spi_csb  in  1  SPI chip select, active low.
- new_playerX, new_playerY, new_facingX, new_facingY, new_vplaneX, new_vplaneY  out  W each  staged vector set.
- write_new_position  out  1  set valid; sampled by consumer at tick.
- frame_err  out  1  one-cycle pulse on a rejected SPI frame.

Behaviour:
- Reset (reset_n low at a clk edge):
  - all new_* = 0; write_new_position = 0; frame_err = 0.
  - Shift register and bit counter cleared.
  - Synchronizer flops cleared to sclk=0, mosi=0, csb=1.
- Synchronization:
  - spi_sclk, spi_mosi and spi_csb each pass through a 2-FF synchronizer, plus a third flop for edge detection.
  - All logic below uses synchronized signals only.
- Receive state machine IDLE / SHIFT:
  - IDLE → SHIFT on synchronized csb falling edge; counter cleared to 0.
  - In SHIFT, on each synchronized sclk rising edge:
    - shift register = {shift[L-2:0], mosi}, where L = NVEC*W (144 bits; 152 with the optional feature).
    - Counter increments and saturates at 255.
  - SHIFT → IDLE on csb rising edge. Accept only if counter == L exactly (and the checksum matches when enabled).
  - Any other count: discard the set and pulse frame_err for 1 cycle; outputs unchanged.
  - sclk edges while csb is high are ignored.
- Accept (cycle after csb rise is detected):
  - All six new_* load simultaneously from the shift register; first-received W bits → new_playerX.
  - write_new_position ← 1.
- Consume:
  - If write_new_position==1 and tick==1 in a cycle with no accept, write_new_position ← 0 on the next cycle.
  - new_* hold their values.
- Simultaneous accept and tick: accept wins. new_* update and write_new_position = 1 next cycle.
  - The consumer at that tick sees either the previous complete set or write_new_position=0, never a mixed set.
- Back-to-back frames before a tick: last accepted set wins; no queueing.
- Latency: csb rising pin edge → write_new_position high = 4 clk cycles (3 sync/edge + 1 load).
- Reset mid-frame discards the partial frame with no frame_err pulse.

Optional Feature:
- Macro: POV_LOADER_CHECKSUM_EN.
- With it defined:
  - Each frame carries an extra trailing byte: the XOR of the 18 data bytes. L = 152.
  - Accept requires count==152 and a checksum match.
  - A mismatch discards the set and pulses frame_err.
- Without it: L = 144, no checksum byte; a 152-bit frame is a length error.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles → all new_* = 0x000000, write_new_position=0, frame_err=0.
- Good frame, sclk = clk/4: send playerX=0x001800 (1.5), playerY=0x00D800 (13.5), facingX=0x000000, facingY=0xFFF000 (-1.0), vplaneX=0x000800 (0.5), vplaneY=0x000000.
  - Expected: 4 cycles after csb rise, outputs equal these values and write_new_position=1.
  - Apply tick → write_new_position=0 next cycle; values held.
- Short frame of 143 bits → frame_err pulses exactly 1 cycle; new_* and write_new_position unchanged.
- Accept coincident with tick (csb timed so the load cycle equals the tick cycle) → new_* take the new set; write_new_position=1 after that tick.
  - Next tick clears write_new_position.
- Two good frames (playerX 0x001800, then 0x002800) with no tick between → outputs show 0x002800; one tick clears write_new_position.
- With POV_LOADER_CHECKSUM_EN: 152-bit frame with a corrupted checksum byte → frame_err pulse, outputs unchanged.
  - The same frame with the correct XOR is accepted.
